// File: rtl/regfile_pkg.sv
// Shared register-file write-port definitions: widths, arbiter state and write payload.
package regfile_pkg;

    localparam int unsigned RF_ADR_W    = 6;
    localparam int unsigned RF_DATA_W   = 64;
    localparam int unsigned RF_NUM_REGS = 64;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [RF_ADR_W-1:0]  adr;
        logic [RF_DATA_W-1:0] data;
        logic                 en;
    } rf_write_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester after ptr, wrapping.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    int unsigned pos;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        pos     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = (32'(ptr) + k) % NUM_REQ;
            if (!any_c && valid[SEL_W'(pos)]) begin
                any_c                 = 1'b1;
                grant_c[SEL_W'(pos)]  = 1'b1;
                idx_c                 = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port, preceded by a zeroing sweep.
// Optional: REGFILE_ZERO_PROTECT_EN suppresses RUN-phase writes to register 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADR_W    = RF_ADR_W,
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADR_W-1:0]    req_adr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADR_W-1:0]            writeAdr,
    output logic [DATA_W-1:0]           writeData,
    output logic                        writeEnable,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        init_done
);

    state_e              state_q, state_d;
    logic [ADR_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                init_done_q, init_done_d;
    rf_write_t           wr_q, wr_d;

    logic [NUM_REQ-1:0]  grant_c;
    logic [IDX_W-1:0]    idx_c;
    logic                any_c;
    logic [ADR_W-1:0]    sel_adr_c;
    logic [DATA_W-1:0]   sel_data_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid   (req_valid),
        .ptr     (ptr_q),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_adr_c  = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_adr_c  = req_adr[i*ADR_W +: ADR_W];
                sel_data_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        wr_d        = wr_q;
        wr_d.en     = 1'b0;
        init_done_d = (state_q == ST_RUN);
        req_ready   = '0;

        case (state_q)
            ST_INIT: begin
                wr_d.en   = 1'b1;
                wr_d.adr  = RF_ADR_W'(cnt_q);
                wr_d.data = '0;
                cnt_d     = cnt_q + ADR_W'(1);
                if (cnt_q == ADR_W'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = grant_c;
                if (any_c) begin
                    ptr_d      = idx_c;
                    grant_id_d = idx_c;
                    wr_d.adr   = RF_ADR_W'(sel_adr_c);
                    wr_d.data  = RF_DATA_W'(sel_data_c);
`ifdef REGFILE_ZERO_PROTECT_EN
                    wr_d.en    = (sel_adr_c != '0);
`else
                    wr_d.en    = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            init_done_q <= 1'b0;
            wr_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            init_done_q <= init_done_d;
            wr_q        <= wr_d;
        end
    end

    assign writeAdr    = ADR_W'(wr_q.adr);
    assign writeData   = DATA_W'(wr_q.data);
    assign writeEnable = wr_q.en;
    assign grant_id    = grant_id_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: sweep, arbitration table, reset and zero-protect.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
`ifdef REGFILE_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*6-1:0]   req_adr;
    logic [NREQ*64-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [5:0]          writeAdr;
    logic [63:0]         writeData;
    logic                writeEnable;
    logic [2:0]          grant_id;
    logic                init_done;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_adr     (req_adr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .writeAdr    (writeAdr),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .grant_id    (grant_id),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;
        logic [23:0]  adr;
        logic [255:0] data;
        logic [3:0]   rdy;
    } vec_t;

    typedef struct {
        logic        en;
        logic        chk_ad;
        logic [5:0]  adr;
        logic [63:0] data;
        logic [2:0]  gid;
    } exp_t;

    vec_t  tbl[$];
    exp_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [2:0]  m_gid;
    logic [5:0]  m_last_adr;
    logic [63:0] m_last_data;
    logic        m_last_known;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [3:0] v, input logic [3:0] rdy);
        vec_t e;
        int k;
        k = tbl.size();
        e.valid = v;
        e.rdy   = rdy;
        for (int i = 0; i < NREQ; i++) begin
            e.adr[i*6 +: 6]    = 6'(1 + ((k * 4 + i) % 63));
            e.data[i*64 +: 64] = {32'(k), 32'($urandom) ^ 32'(i)};
        end
        tbl.push_back(e);
    endtask

    // Called at posedge+1: drive, check ready at negedge, push expectation, compare after edge.
    task automatic step(input logic [3:0] v, input logic [23:0] a, input logic [255:0] d,
                        input logic [3:0] exp_rdy, input string nm);
        exp_t e;
        exp_t got;
        int idx;
        logic [5:0]  sa;
        logic [63:0] sd;
        req_valid = v;
        req_adr   = a;
        req_data  = d;
        #4;
        check({nm, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) idx = i;
        if (idx >= 0) begin
            sa = 6'(a >> (idx * 6));
            sd = 64'(d >> (idx * 64));
            m_gid = 3'(idx);
            if (ZP && sa == 6'd0) begin
                e.en = 1'b0; e.chk_ad = 1'b0; e.adr = sa; e.data = sd;
                m_last_known = 1'b0;
            end else begin
                e.en = 1'b1; e.chk_ad = 1'b1; e.adr = sa; e.data = sd;
                m_last_adr = sa; m_last_data = sd; m_last_known = 1'b1;
            end
        end else begin
            e.en = 1'b0; e.chk_ad = m_last_known; e.adr = m_last_adr; e.data = m_last_data;
        end
        e.gid = m_gid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({nm, ".we"}, 64'(writeEnable), 64'(got.en));
        if (got.chk_ad) begin
            check({nm, ".adr"}, 64'(writeAdr), 64'(got.adr));
            check({nm, ".data"}, writeData, got.data);
        end
        check({nm, ".gid"}, 64'(grant_id), 64'(got.gid));
    endtask

    // Called at posedge+1 with rst low; requests stay high during INIT and must be ignored.
    task automatic sweep(input string nm);
        req_valid = 4'b1111;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk);
            #1;
            check({nm, ".we"}, 64'(writeEnable), 64'd1);
            check({nm, ".adr"}, 64'(writeAdr), 64'(c));
            check({nm, ".data"}, writeData, 64'd0);
            check({nm, ".init_done"}, 64'(init_done), 64'd0);
            if (c <= 62) check({nm, ".ready"}, 64'(req_ready), 64'd0);
            if (c == 62) req_valid = 4'b0000;
        end
        @(posedge clk);
        #1;
        check({nm, ".init_done_rise"}, 64'(init_done), 64'd1);
        check({nm, ".we_after"}, 64'(writeEnable), 64'd0);
        check({nm, ".adr_hold"}, 64'(writeAdr), 64'd63);
        m_gid = 3'd0;
        m_last_adr = 6'd63;
        m_last_data = 64'd0;
        m_last_known = 1'b1;
    endtask

    initial begin
        vec_t e;
        logic [23:0]  a;
        logic [255:0] d;

        rst = 1'b1;
        req_valid = '0;
        req_adr = '0;
        req_data = '0;

        add_vec(4'b0100, 4'b0100);
        tbl[0].adr[12 +: 6]   = 6'd5;
        tbl[0].data[128 +: 64] = 64'hDEAD;
        add_vec(4'b0000, 4'b0000);
        add_vec(4'b1111, 4'b1000);
        add_vec(4'b1111, 4'b0001);
        add_vec(4'b1111, 4'b0010);
        add_vec(4'b1111, 4'b0100);
        add_vec(4'b1111, 4'b1000);
        add_vec(4'b1111, 4'b0001);
        add_vec(4'b1111, 4'b0010);
        add_vec(4'b1111, 4'b0100);
        add_vec(4'b1000, 4'b1000);
        add_vec(4'b1010, 4'b0010);
        add_vec(4'b1010, 4'b1000);
        add_vec(4'b1010, 4'b0010);
        add_vec(4'b0000, 4'b0000);
        add_vec(4'b0011, 4'b0001);
        add_vec(4'b0011, 4'b0010);
        add_vec(4'b0101, 4'b0100);
        add_vec(4'b0101, 4'b0001);

        repeat (2) @(posedge clk);
        #1;
        check("rst.we", 64'(writeEnable), 64'd0);
        check("rst.adr", 64'(writeAdr), 64'd0);
        check("rst.data", writeData, 64'd0);
        check("rst.gid", 64'(grant_id), 64'd0);
        check("rst.init_done", 64'(init_done), 64'd0);
        check("rst.ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        sweep("sweep0");

        for (int k = 0; k < tbl.size(); k++) begin
            e = tbl[k];
            step(e.valid, e.adr, e.data, e.rdy, $sformatf("vec%0d", k));
        end

        // Requester 0 writes register 0.
        a = '0;
        d = '0;
        d[63:0] = 64'd7;
        step(4'b0001, a, d, 4'b0001, "zero_adr");

        // Reset while a write is on the port.
        a = '0;
        d = '0;
        a[6 +: 6] = 6'd33;
        d[64 +: 64] = 64'hBAD0_CAFE_0000_1234;
        step(4'b0010, a, d, 4'b0010, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("midrst.we", 64'(writeEnable), 64'd0);
        check("midrst.init_done", 64'(init_done), 64'd0);
        check("midrst.adr", 64'(writeAdr), 64'd0);
        check("midrst.ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep("sweep1");

        step(4'b1111, a, d, 4'b0001, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
